execute_stage: RTL and testbench

EXECUTE_STAGE -- requirements
Module: execute_stage

---
 rtl/execute_stage_if.sv | 45 ++++
 rtl/execute_stage.sv | 260 ++++++++++++++++++++++++++
 tb/tb_execute_stage.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/execute_stage_if.sv
// ID/EX operand and control bundle into the execute stage, EX/MEM register fields and stall out of it.
// master = upstream pipeline side, slave = execute_stage.
interface execute_stage_if #(
    parameter int P_DATA_WIDTH = 32,
    parameter int P_PC_WIDTH   = 11
) ();
    logic                    i_regwrite_e;
    logic                    i_memwrite_e;
    logic [1:0]              i_resultsrc_e;
    logic                    i_alusrc_e;
    logic [3:0]              i_alu_ctrl_e;
    logic                    i_muldiv_e;
    logic [2:0]              i_f3_e;
    logic [P_DATA_WIDTH-1:0] i_rs1_data_e;
    logic [P_DATA_WIDTH-1:0] i_rs2_data_e;
    logic [P_DATA_WIDTH-1:0] i_imm_e;
    logic [4:0]              i_rd_addr_e;
    logic [P_PC_WIDTH-1:0]   i_pc4_e;
    logic                    i_flush_e;
    logic                    o_stall_e;
    logic                    o_regwrite_m;
    logic                    o_memwrite_m;
    logic [1:0]              o_resultsrc_m;
    logic [P_DATA_WIDTH-1:0] o_alu_result_m;
    logic [P_DATA_WIDTH-1:0] o_write_data_m;
    logic [4:0]              o_rd_addr_m;
    logic [P_PC_WIDTH-1:0]   o_pc4_m;
    logic [2:0]              o_f3_m;

    modport master (
        output i_regwrite_e, i_memwrite_e, i_resultsrc_e, i_alusrc_e, i_alu_ctrl_e,
               i_muldiv_e, i_f3_e, i_rs1_data_e, i_rs2_data_e, i_imm_e, i_rd_addr_e,
               i_pc4_e, i_flush_e,
        input  o_stall_e, o_regwrite_m, o_memwrite_m, o_resultsrc_m, o_alu_result_m,
               o_write_data_m, o_rd_addr_m, o_pc4_m, o_f3_m
    );

    modport slave (
        input  i_regwrite_e, i_memwrite_e, i_resultsrc_e, i_alusrc_e, i_alu_ctrl_e,
               i_muldiv_e, i_f3_e, i_rs1_data_e, i_rs2_data_e, i_imm_e, i_rd_addr_e,
               i_pc4_e, i_flush_e,
        output o_stall_e, o_regwrite_m, o_memwrite_m, o_resultsrc_m, o_alu_result_m,
               o_write_data_m, o_rd_addr_m, o_pc4_m, o_f3_m
    );
endinterface

// File: rtl/execute_stage.sv
// Execute stage: ALU, single-cycle RV32M multiply and EX/MEM register.
// Define RV32M_DIV_EN to build the iterative restoring divider; without it divide/remainder return 0.
module execute_stage #(
    parameter int P_DATA_WIDTH = 32,
    parameter int P_PC_WIDTH   = 11
) (
    input  logic           i_clk,
    input  logic           i_rst,
    execute_stage_if.slave ex
);
    localparam int W = P_DATA_WIDTH;

    typedef struct packed {
        logic                  regwrite;
        logic                  memwrite;
        logic [1:0]            resultsrc;
        logic [W-1:0]          alu_result;
        logic [W-1:0]          write_data;
        logic [4:0]            rd_addr;
        logic [P_PC_WIDTH-1:0] pc4;
        logic [2:0]            f3;
    } exmem_t;

    localparam exmem_t C_BUBBLE = {$bits(exmem_t){1'b0}};

    logic [W-1:0]   b_s;
    logic [W-1:0]   alu_s;
    logic [W-1:0]   mul_s;
    logic [W-1:0]   ex_res_s;
    logic [2*W-1:0] mul_a_s;
    logic [2*W-1:0] mul_b_s;
    logic [2*W-1:0] prod_s;
    logic           mul_a_signed_s;
    logic           mul_b_signed_s;
    exmem_t         live_s;
    exmem_t         div_pl_s;
    exmem_t         exmem_r;
    logic           stall_s;
    logic           bubble_sel_s;
    logic           done_sel_s;

    assign b_s = ex.i_alusrc_e ? ex.i_imm_e : ex.i_rs2_data_e;

    // ALU operation decode
    always_comb begin
        alu_s = {W{1'b0}};
        case (ex.i_alu_ctrl_e)
            4'd0:    alu_s = ex.i_rs1_data_e + b_s;
            4'd1:    alu_s = ex.i_rs1_data_e - b_s;
            4'd2:    alu_s = ex.i_rs1_data_e & b_s;
            4'd3:    alu_s = ex.i_rs1_data_e | b_s;
            4'd4:    alu_s = ex.i_rs1_data_e ^ b_s;
            4'd5:    alu_s = ex.i_rs1_data_e << b_s[4:0];
            4'd6:    alu_s = ex.i_rs1_data_e >> b_s[4:0];
            4'd7:    alu_s = $signed(ex.i_rs1_data_e) >>> b_s[4:0];
            4'd8:    alu_s = {{(W-1){1'b0}}, ($signed(ex.i_rs1_data_e) < $signed(b_s))};
            4'd9:    alu_s = {{(W-1){1'b0}}, (ex.i_rs1_data_e < b_s)};
            default: alu_s = {W{1'b0}};
        endcase
    end

    // One shared 2W-bit multiplier; operand extension picks signed/mixed/unsigned, and the low half is sign-agnostic
    assign mul_a_signed_s = (ex.i_f3_e[1:0] != 2'b11);
    assign mul_b_signed_s = (ex.i_f3_e[1:0] == 2'b01);
    assign mul_a_s = {{W{mul_a_signed_s & ex.i_rs1_data_e[W-1]}}, ex.i_rs1_data_e};
    assign mul_b_s = {{W{mul_b_signed_s & ex.i_rs2_data_e[W-1]}}, ex.i_rs2_data_e};
    assign prod_s  = mul_a_s * mul_b_s;

    // M-extension result select; divide codes read 0 here and the divider supplies its own result
    always_comb begin
        mul_s = {W{1'b0}};
        if (ex.i_f3_e[2]) begin
            mul_s = {W{1'b0}};
        end else if (ex.i_f3_e[1:0] == 2'b00) begin
            mul_s = prod_s[W-1:0];
        end else begin
            mul_s = prod_s[2*W-1:W];
        end
    end

    assign ex_res_s = ex.i_muldiv_e ? mul_s : alu_s;

    // Payload for the instruction currently in EX
    always_comb begin
        live_s            = C_BUBBLE;
        live_s.regwrite   = ex.i_regwrite_e;
        live_s.memwrite   = ex.i_memwrite_e;
        live_s.resultsrc  = ex.i_resultsrc_e;
        live_s.alu_result = ex_res_s;
        live_s.write_data = ex.i_rs2_data_e;
        live_s.rd_addr    = ex.i_rd_addr_e;
        live_s.pc4        = ex.i_pc4_e;
        live_s.f3         = ex.i_f3_e;
    end

`ifdef RV32M_DIV_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} div_state_e;

    div_state_e   state_r;
    div_state_e   state_nxt_s;
    logic [5:0]   count_r;
    logic [W-1:0] quo_r;
    logic [W-1:0] rem_r;
    logic [W-1:0] dvs_r;
    logic         neg_q_r;
    logic         neg_r_r;
    exmem_t       hold_r;
    logic         is_div_s;
    logic         signed_s;
    logic         a_neg_s;
    logic         b_neg_s;
    logic [W-1:0] a_mag_s;
    logic [W-1:0] b_mag_s;
    logic         div_zero_s;
    logic         div_ovf_s;
    logic         issue_s;
    logic [W:0]   trial_s;
    logic [W:0]   diff_s;
    logic [W-1:0] q_fix_s;
    logic [W-1:0] r_fix_s;

    assign is_div_s   = ex.i_muldiv_e & ex.i_f3_e[2];
    assign signed_s   = ~ex.i_f3_e[0];
    assign a_neg_s    = signed_s & ex.i_rs1_data_e[W-1];
    assign b_neg_s    = signed_s & ex.i_rs2_data_e[W-1];
    assign a_mag_s    = a_neg_s ? -ex.i_rs1_data_e : ex.i_rs1_data_e;
    assign b_mag_s    = b_neg_s ? -ex.i_rs2_data_e : ex.i_rs2_data_e;
    assign div_zero_s = (ex.i_rs2_data_e == {W{1'b0}});
    assign div_ovf_s  = signed_s & (ex.i_rs1_data_e == {1'b1, {(W-1){1'b0}}})
                                 & (ex.i_rs2_data_e == {W{1'b1}});
    assign issue_s    = (state_r == S_IDLE) & is_div_s & ~ex.i_flush_e & ~i_rst;
    assign trial_s    = {rem_r, quo_r[W-1]};
    assign diff_s     = trial_s - {1'b0, dvs_r};
    assign q_fix_s    = neg_q_r ? -quo_r : quo_r;
    assign r_fix_s    = neg_r_r ? -rem_r : rem_r;

    // Divider state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Divider next state and pipeline control; reset and flush override any divide in flight
    always_comb begin
        state_nxt_s  = state_r;
        stall_s      = 1'b0;
        bubble_sel_s = 1'b0;
        done_sel_s   = 1'b0;
        if (i_rst || ex.i_flush_e) begin
            state_nxt_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (is_div_s) begin
                        stall_s      = 1'b1;
                        bubble_sel_s = 1'b1;
                        state_nxt_s  = (div_zero_s || div_ovf_s) ? S_DONE : S_BUSY;
                    end else begin
                        state_nxt_s  = S_IDLE;
                    end
                end
                S_BUSY: begin
                    stall_s      = 1'b1;
                    bubble_sel_s = 1'b1;
                    if (count_r == 6'd31) begin
                        state_nxt_s = S_DONE;
                    end else begin
                        state_nxt_s = S_BUSY;
                    end
                end
                S_DONE: begin
                    done_sel_s  = 1'b1;
                    state_nxt_s = S_IDLE;
                end
                default: state_nxt_s = S_IDLE;
            endcase
        end
    end

    // Divider datapath: capture magnitudes at issue, then one restoring step per BUSY cycle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_r <= 6'd0;
            quo_r   <= {W{1'b0}};
            rem_r   <= {W{1'b0}};
            dvs_r   <= {W{1'b0}};
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            hold_r  <= C_BUBBLE;
        end else if (issue_s) begin
            count_r <= 6'd0;
            dvs_r   <= b_mag_s;
            hold_r  <= live_s;
            if (div_zero_s) begin
                quo_r   <= {W{1'b1}};
                rem_r   <= ex.i_rs1_data_e;
                neg_q_r <= 1'b0;
                neg_r_r <= 1'b0;
            end else if (div_ovf_s) begin
                quo_r   <= {1'b1, {(W-1){1'b0}}};
                rem_r   <= {W{1'b0}};
                neg_q_r <= 1'b0;
                neg_r_r <= 1'b0;
            end else begin
                quo_r   <= a_mag_s;
                rem_r   <= {W{1'b0}};
                neg_q_r <= a_neg_s ^ b_neg_s;
                neg_r_r <= a_neg_s;
            end
        end else if (state_r == S_BUSY) begin
            count_r <= count_r + 6'd1;
            quo_r   <= {quo_r[W-2:0], ~diff_s[W]};
            rem_r   <= diff_s[W] ? trial_s[W-1:0] : diff_s[W-1:0];
        end
    end

    // Finished divide: held controls with the sign-corrected quotient or remainder
    always_comb begin
        div_pl_s = hold_r;
        if (hold_r.f3[1]) begin
            div_pl_s.alu_result = r_fix_s;
        end else begin
            div_pl_s.alu_result = q_fix_s;
        end
    end
`else
    assign stall_s      = 1'b0;
    assign bubble_sel_s = 1'b0;
    assign done_sel_s   = 1'b0;
    assign div_pl_s     = C_BUBBLE;
`endif

    // EX/MEM pipeline register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            exmem_r <= C_BUBBLE;
        end else if (ex.i_flush_e) begin
            exmem_r <= C_BUBBLE;
        end else if (done_sel_s) begin
            exmem_r <= div_pl_s;
        end else if (bubble_sel_s) begin
            exmem_r <= C_BUBBLE;
        end else begin
            exmem_r <= live_s;
        end
    end

    assign ex.o_stall_e      = stall_s;
    assign ex.o_regwrite_m   = exmem_r.regwrite;
    assign ex.o_memwrite_m   = exmem_r.memwrite;
    assign ex.o_resultsrc_m  = exmem_r.resultsrc;
    assign ex.o_alu_result_m = exmem_r.alu_result;
    assign ex.o_write_data_m = exmem_r.write_data;
    assign ex.o_rd_addr_m    = exmem_r.rd_addr;
    assign ex.o_pc4_m        = exmem_r.pc4;
    assign ex.o_f3_m         = exmem_r.f3;
endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage; divider scenarios apply when RV32M_DIV_EN is defined.
`timescale 1ns/1ps
module tb_execute_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    execute_stage_if #(.P_DATA_WIDTH(32), .P_PC_WIDTH(11)) bus ();
    execute_stage #(.P_DATA_WIDTH(32), .P_PC_WIDTH(11)) dut (.i_clk(clk), .i_rst(rst), .ex(bus));

    always #5 clk = ~clk;

    // ALU vectors: ctrl, rs1, rs2, imm, alusrc, expected result
    logic [3:0]  alu_ctrl [12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd12, 4'd0};
    logic [31:0] alu_a    [12] = '{32'd5, 32'd3, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'd1,
                                   32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF};
    logic [31:0] alu_b    [12] = '{32'h1234, 32'd5, 32'h0FF00FF0, 32'h0FF00FF0, 32'h0FF00FF0, 32'd0,
                                   32'd4, 32'd4, 32'd1, 32'd1, 32'd6, 32'd2};
    logic [31:0] alu_imm  [12] = '{32'hFFFFFFFD, 32'd0, 32'd0, 32'd0, 32'd0, 32'h23,
                                   32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    logic        alu_src  [12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] alu_exp  [12] = '{32'd2, 32'hFFFFFFFE, 32'h00F000F0, 32'hFFF0FFF0, 32'hFF00FF00, 32'd8,
                                   32'h08000000, 32'hF8000000, 32'd1, 32'd0, 32'd0, 32'd1};

    // Multiply vectors: f3, rs1, rs2, expected result
    logic [2:0]  mul_f3  [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd1, 3'd2};
    logic [31:0] mul_a   [6] = '{32'd7, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] mul_b   [6] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2};
    logic [31:0] mul_exp [6] = '{32'hFFFFFFEB, 32'h40000000, 32'h80000000, 32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF};

    task automatic set_op(input logic [3:0] ctrl, input logic md, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                          input logic src, input logic rw);
        bus.i_alu_ctrl_e  = ctrl;
        bus.i_muldiv_e    = md;
        bus.i_f3_e        = f3;
        bus.i_rs1_data_e  = a;
        bus.i_rs2_data_e  = b;
        bus.i_imm_e       = imm;
        bus.i_alusrc_e    = src;
        bus.i_regwrite_e  = rw;
        bus.i_memwrite_e  = 1'b0;
        bus.i_resultsrc_e = 2'b01;
        bus.i_rd_addr_e   = 5'd9;
        bus.i_pc4_e       = 11'h123;
        bus.i_flush_e     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_op(4'd0, 1'b1, 3'b100, 32'd100, 32'd7, 32'd0, 1'b0, 1'b1);
        bus.i_memwrite_e = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.o_stall_e !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", bus.o_stall_e); end
        n_checks++;
        if (bus.o_regwrite_m !== 1'b0 || bus.o_memwrite_m !== 1'b0 || bus.o_resultsrc_m !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_ctrl: got rw=%b mw=%b rs=%b expected 0", bus.o_regwrite_m, bus.o_memwrite_m, bus.o_resultsrc_m);
        end
        n_checks++;
        if (bus.o_alu_result_m !== 32'd0 || bus.o_write_data_m !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_data: got alu=%h wd=%h expected 0", bus.o_alu_result_m, bus.o_write_data_m);
        end
        n_checks++;
        if (bus.o_rd_addr_m !== 5'd0 || bus.o_pc4_m !== 11'd0 || bus.o_f3_m !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_fields: got rd=%h pc4=%h f3=%h expected 0", bus.o_rd_addr_m, bus.o_pc4_m, bus.o_f3_m);
        end
        @(negedge clk);
        set_op(4'd0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_alu();
        logic [56:0] exp_pt;
        logic [56:0] got_pt;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            set_op(alu_ctrl[i], 1'b0, 3'(i), alu_a[i], alu_b[i], alu_imm[i], alu_src[i], 1'b1);
            bus.i_memwrite_e  = i[0];
            bus.i_resultsrc_e = i[1:0];
            bus.i_rd_addr_e   = 5'(i + 1);
            bus.i_pc4_e       = 11'(32'h100 + i);
            @(posedge clk);
            #1;
            n_checks++;
            if (bus.o_alu_result_m !== alu_exp[i]) begin
                n_fail++;
                $display("FAIL alu_%0d: got %h expected %h", i, bus.o_alu_result_m, alu_exp[i]);
            end
            exp_pt = {1'b1, i[0], i[1:0], alu_b[i], 5'(i + 1), 11'(32'h100 + i), 3'(i), bus.o_stall_e & 1'b0};
            got_pt = {bus.o_regwrite_m, bus.o_memwrite_m, bus.o_resultsrc_m, bus.o_write_data_m,
                      bus.o_rd_addr_m, bus.o_pc4_m, bus.o_f3_m, bus.o_stall_e};
            n_checks++;
            if (got_pt !== exp_pt) begin
                n_fail++;
                $display("FAIL alu_pass_%0d: got %h expected %h", i, got_pt, exp_pt);
            end
        end
    endtask

    task automatic test_mul();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            set_op(4'd0, 1'b1, mul_f3[i], mul_a[i], mul_b[i], 32'hDEADBEEF, 1'b1, 1'b1);
            @(posedge clk);
            #1;
            n_checks++;
            if (bus.o_alu_result_m !== mul_exp[i] || bus.o_stall_e !== 1'b0) begin
                n_fail++;
                $display("FAIL mul_%0d: got %h stall=%b expected %h stall=0", i, bus.o_alu_result_m, bus.o_stall_e, mul_exp[i]);
            end
        end
    endtask

`ifdef RV32M_DIV_EN
    task automatic run_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           output int stalls, output logic [31:0] res, output logic rw, output int bub_bad);
        stalls  = 0;
        bub_bad = 0;
        @(negedge clk);
        set_op(4'd0, 1'b1, f3, a, b, 32'h5555AAAA, 1'b1, 1'b1);
        for (int k = 0; k < 40; k++) begin
            #1;
            if (bus.o_stall_e !== 1'b1) break;
            stalls++;
            @(posedge clk);
            #1;
            if (bus.o_regwrite_m !== 1'b0 || bus.o_memwrite_m !== 1'b0) bub_bad++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        res = bus.o_alu_result_m;
        rw  = bus.o_regwrite_m;
        @(negedge clk);
        set_op(4'd0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic test_div();
        logic [2:0]  f3v  [6] = '{3'b100, 3'b110, 3'b101, 3'b101, 3'b110, 3'b100};
        logic [31:0] av   [6] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd9, 32'd9, 32'h80000000};
        logic [31:0] bv   [6] = '{32'd2, 32'd2, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF};
        logic [31:0] ev   [6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'hFFFFFFFF, 32'd9, 32'h80000000};
        int          sv   [6] = '{33, 33, 33, 1, 1, 1};
        int          st;
        int          bad;
        logic [31:0] res;
        logic        rw;
        for (int i = 0; i < 6; i++) begin
            run_div(f3v[i], av[i], bv[i], st, res, rw, bad);
            n_checks++;
            if (st != sv[i]) begin n_fail++; $display("FAIL div_stall_%0d: got %0d cycles expected %0d", i, st, sv[i]); end
            n_checks++;
            if (res !== ev[i] || rw !== 1'b1) begin
                n_fail++;
                $display("FAIL div_result_%0d: got %h rw=%b expected %h rw=1", i, res, rw, ev[i]);
            end
            n_checks++;
            if (bad != 0) begin n_fail++; $display("FAIL div_bubble_%0d: got %0d non-bubble cycles expected 0", i, bad); end
        end
    endtask

    task automatic test_flush();
        int bad = 0;
        @(negedge clk);
        set_op(4'd0, 1'b1, 3'b100, 32'd100, 32'd7, 32'd0, 1'b0, 1'b1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.i_flush_e = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.o_regwrite_m !== 1'b0 || bus.o_alu_result_m !== 32'd0) begin
            n_fail++;
            $display("FAIL flush_bubble: got rw=%b alu=%h expected 0", bus.o_regwrite_m, bus.o_alu_result_m);
        end
        @(negedge clk);
        set_op(4'd0, 1'b0, 3'd0, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1);
        #1;
        n_checks++;
        if (bus.o_stall_e !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b expected 0", bus.o_stall_e); end
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.o_alu_result_m !== 32'd3 || bus.o_regwrite_m !== 1'b1 || bus.o_stall_e !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL flush_no_result: got %0d bad cycles expected 0", bad); end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        @(negedge clk);
        set_op(4'd0, 1'b1, 3'b100, 32'd100, 32'd7, 32'd0, 1'b0, 1'b1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.o_stall_e !== 1'b0) begin n_fail++; $display("FAIL rstmid_stall: got %b expected 0", bus.o_stall_e); end
        @(posedge clk);
        #1;
        n_checks++;
        if ({bus.o_regwrite_m, bus.o_memwrite_m, bus.o_resultsrc_m, bus.o_alu_result_m, bus.o_write_data_m,
             bus.o_rd_addr_m, bus.o_pc4_m, bus.o_f3_m} !== 89'd0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got alu=%h rw=%b rd=%h expected all 0", bus.o_alu_result_m, bus.o_regwrite_m, bus.o_rd_addr_m);
        end
        @(negedge clk);
        set_op(4'd0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.o_stall_e !== 1'b0 || bus.o_regwrite_m !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL rstmid_no_result: got %0d bad cycles expected 0", bad); end
    endtask
`else
    task automatic test_div_disabled();
        int bad = 0;
        @(negedge clk);
        set_op(4'd0, 1'b1, 3'b100, 32'd100, 32'd7, 32'd0, 1'b0, 1'b1);
        #1;
        n_checks++;
        if (bus.o_stall_e !== 1'b0) begin n_fail++; $display("FAIL nodiv_stall: got %b expected 0", bus.o_stall_e); end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.o_alu_result_m !== 32'd0 || bus.o_regwrite_m !== 1'b1) begin
            n_fail++;
            $display("FAIL nodiv_div: got %h rw=%b expected 0 rw=1", bus.o_alu_result_m, bus.o_regwrite_m);
        end
        @(negedge clk);
        set_op(4'd0, 1'b1, 3'b111, 32'd9, 32'd4, 32'd0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.o_alu_result_m !== 32'd0) begin n_fail++; $display("FAIL nodiv_remu: got %h expected 0", bus.o_alu_result_m); end
        @(negedge clk);
        set_op(4'd0, 1'b1, 3'b100, 32'd100, 32'd7, 32'd0, 1'b0, 1'b1);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (bus.o_stall_e !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL nodiv_never_stall: got %0d stall cycles expected 0", bad); end
        @(negedge clk);
        set_op(4'd0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_mul();
`ifdef RV32M_DIV_EN
        test_div();
        test_flush();
        test_reset_mid();
`else
        test_div_disabled();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
